// File: rtl/bp_pktfifo_arbiter.sv
// rtl/bp_pktfifo_arbiter.sv - round-robin packet FIFO to BytePipe arbiter with flush sequencing
module bp_pktfifo_arbiter #(
   parameter int N_ENGINE = 2,
   parameter int PKT_LEN  = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_cg,
   input  logic [N_ENGINE*8-1:0] i_pktfifo_data,
   input  logic [N_ENGINE-1:0]   i_pktfifo_empty,
   input  logic [N_ENGINE-1:0]   i_pktReady,
   output logic [N_ENGINE-1:0]   o_pktfifo_pop,
   output logic [N_ENGINE-1:0]   o_pktfifo_flush,
   input  logic [N_ENGINE-1:0]   i_engineEn,
   input  logic [N_ENGINE-1:0]   i_flush,
   output logic [7:0]            o_bp_data,
   output logic                  o_bp_valid,
   input  logic                  i_bp_ready,
   output logic                  o_busy
);

   localparam int SEL_W = (N_ENGINE > 1) ? $clog2(N_ENGINE) : 1;
   localparam int CNT_W = $clog2(PKT_LEN + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEADER = 2'd1,
      BODY   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [SEL_W-1:0]    last_q, last_d;
   logic [SEL_W-1:0]    gnt_idx, cand;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [N_ENGINE-1:0] flush_pend_q, flush_pend_d;
   logic [N_ENGINE-1:0] elig, sel_oh, flush_fire;
   logic                gnt_found;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= IDLE;
         sel_q        <= '0;
         last_q       <= SEL_W'(N_ENGINE - 1);
         cnt_q        <= '0;
         flush_pend_q <= '0;
      end else if (i_cg) begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         last_q       <= last_d;
         cnt_q        <= cnt_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   assign elig = i_pktReady & i_engineEn & ~flush_pend_q;

   // First eligible engine after the previous grant, wrapping modulo N_ENGINE.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= N_ENGINE; i++) begin
         cand = SEL_W'((int'(last_q) + i) % N_ENGINE);
         if (!gnt_found && elig[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   always_comb begin
      sel_oh        = '0;
      sel_oh[sel_q] = 1'b1;
   end

   // The active engine's flush waits until its packet has fully drained.
   assign flush_fire      = flush_pend_q & ~((state_q != IDLE) ? sel_oh : '0);
   assign flush_pend_d    = (flush_pend_q & ~flush_fire) | (i_flush & ~flush_pend_q);
   assign o_pktfifo_flush = i_cg ? flush_fire : '0;
   assign o_busy          = (state_q != IDLE);

   always_comb begin
      state_d       = state_q;
      sel_d         = sel_q;
      last_d        = last_q;
      cnt_d         = cnt_q;
      o_bp_valid    = 1'b0;
      o_bp_data     = 8'h00;
      o_pktfifo_pop = '0;
      case (state_q)
         IDLE: begin
            if (gnt_found) begin
               sel_d   = gnt_idx;
               last_d  = gnt_idx;
               cnt_d   = CNT_W'(PKT_LEN);
               state_d = HEADER;
            end
         end
         HEADER: begin
            o_bp_valid = i_cg;
            o_bp_data  = 8'hE0 | 8'(sel_q);
            if (i_bp_ready) begin
               state_d = BODY;
            end
         end
         BODY: begin
            o_bp_data  = i_pktfifo_data[{sel_q, 3'b000} +: 8];
            o_bp_valid = i_cg & ~i_pktfifo_empty[sel_q];
            if (o_bp_valid && i_bp_ready) begin
               o_pktfifo_pop = sel_oh;
               cnt_d         = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_bp_pktfifo_arbiter.sv
// tb/tb_bp_pktfifo_arbiter.sv - directed and randomized bench for bp_pktfifo_arbiter
module tb_bp_pktfifo_arbiter;

   localparam int N = 2;
   localparam int L = 4;

   logic           clk = 1'b0;
   logic           rst_n, cg, bp_ready, bp_valid, busy;
   logic [N*8-1:0] fifo_data;
   logic [N-1:0]   fifo_empty, pkt_ready, pop, fflush, engine_en, flush_req;
   logic [7:0]     bp_data;

   always #5 clk = ~clk;

   bp_pktfifo_arbiter #(.N_ENGINE(N), .PKT_LEN(L)) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_cg            (cg),
      .i_pktfifo_data  (fifo_data),
      .i_pktfifo_empty (fifo_empty),
      .i_pktReady      (pkt_ready),
      .o_pktfifo_pop   (pop),
      .o_pktfifo_flush (fflush),
      .i_engineEn      (engine_en),
      .i_flush         (flush_req),
      .o_bp_data       (bp_data),
      .o_bp_valid      (bp_valid),
      .i_bp_ready      (bp_ready),
      .o_busy          (busy)
   );

   logic [7:0] fmem [N][256];
   int         rd [N];
   int         wr [N];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         m_phase, m_cur, m_last, m_rem;
   logic [N-1:0] m_pend;
   logic [7:0] hs_q[$];
   int         hs_t[$];
   int         pop_cnt [N];
   int         flush_t [N];
   logic [7:0] exp_se [5];
   int         hdr_n, prev_t, t0, pe;

   function automatic int fsize(input int e);
      return wr[e] - rd[e];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int e, input logic [7:0] b);
      fmem[e][wr[e] % 256] = b;
      wr[e]++;
   endtask

   task automatic push_pkt(input int e);
      for (int k = 0; k < L; k++) push(e, 8'($urandom_range(0, 223)));
   endtask

   task automatic drive_fifo();
      for (int e = 0; e < N; e++) begin
         fifo_empty[e]       = (fsize(e) == 0);
         pkt_ready[e]        = (fsize(e) >= L);
         fifo_data[e*8 +: 8] = (fsize(e) > 0) ? fmem[e][rd[e] % 256] : 8'h5A;
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_cur   = 0;
      m_last  = N - 1;
      m_rem   = 0;
      m_pend  = '0;
   endtask

   task automatic clear_logs();
      hs_q.delete();
      hs_t.delete();
      for (int e = 0; e < N; e++) begin
         pop_cnt[e] = 0;
         flush_t[e] = -1;
      end
   endtask

   // One clock: compare at the falling edge, then advance the packet-level model.
   task automatic tick();
      logic [N-1:0] elig, exp_pop, exp_flush;
      logic         exp_valid;
      logic [7:0]   exp_data;
      int           g;
      drive_fifo();
      @(negedge clk);
      for (int e = 0; e < N; e++) elig[e] = pkt_ready[e] & engine_en[e] & ~m_pend[e];
      exp_valid = 1'b0;
      exp_data  = 8'h00;
      exp_pop   = '0;
      if (m_phase == 1) begin
         exp_valid = cg;
         exp_data  = 8'hE0 | 8'(m_cur);
      end else if (m_phase == 2) begin
         exp_valid = cg && (fsize(m_cur) > 0);
         exp_data  = fmem[m_cur][rd[m_cur] % 256];
         if (exp_valid && bp_ready) exp_pop[m_cur] = 1'b1;
      end
      for (int e = 0; e < N; e++)
         exp_flush[e] = cg & m_pend[e] & ~((m_phase != 0) && (m_cur == e));
      chk("valid", bp_valid, exp_valid);
      chk("busy", busy, (m_phase != 0));
      chk("pop", pop, exp_pop);
      chk("flush", fflush, exp_flush);
      if (exp_valid) chk("data", bp_data, exp_data);
      if (bp_valid && bp_ready) begin
         hs_q.push_back(bp_data);
         hs_t.push_back(cyc);
      end
      for (int e = 0; e < N; e++) begin
         if (pop[e]) pop_cnt[e]++;
         if (fflush[e]) flush_t[e] = cyc;
      end
      @(posedge clk);
      if (cg) begin
         if (m_phase == 0) begin
            g = -1;
            for (int k = 1; k <= N; k++)
               if (g < 0 && elig[(m_last + k) % N]) g = (m_last + k) % N;
            if (g >= 0) begin
               m_cur   = g;
               m_last  = g;
               m_rem   = L;
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (bp_ready) m_phase = 2;
         end else if (exp_valid && bp_ready) begin
            rd[m_cur]++;
            m_rem--;
            if (m_rem == 0) m_phase = 0;
         end
         for (int e = 0; e < N; e++) if (exp_flush[e]) rd[e] = wr[e];
         m_pend = (m_pend & ~exp_flush) | (flush_req & ~m_pend);
      end
      #1;
      flush_req = '0;
      cyc++;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      cg        = 1'b1;
      bp_ready  = 1'b0;
      engine_en = '0;
      flush_req = '0;
      for (int e = 0; e < N; e++) begin
         rd[e] = 0;
         wr[e] = 0;
      end
      clear_logs();
      model_reset();
      drive_fifo();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", bp_valid, 1'b0);
      chk("rst_data", bp_data, 8'h00);
      chk("rst_pop", pop, '0);
      chk("rst_flush", fflush, '0);
      chk("rst_busy", busy, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single engine packet on engine1
      engine_en = '1;
      bp_ready  = 1'b1;
      clear_logs();
      push(1, 8'h11); push(1, 8'h22); push(1, 8'h33); push(1, 8'h44);
      repeat (8) tick();
      exp_se = '{8'hE1, 8'h11, 8'h22, 8'h33, 8'h44};
      chk("se_len", hs_q.size(), 5);
      for (int k = 0; k < 5 && k < hs_q.size(); k++) chk("se_byte", hs_q[k], exp_se[k]);
      chk("se_pops1", pop_cnt[1], 4);
      chk("se_pops0", pop_cnt[0], 0);

      // Round-robin with both engines holding two packets
      clear_logs();
      for (int p = 0; p < 2; p++) begin
         push_pkt(0);
         push_pkt(1);
      end
      repeat (26) tick();
      hdr_n  = 0;
      prev_t = 0;
      for (int k = 0; k < hs_q.size(); k++) begin
         if (hs_q[k] >= 8'hE0) begin
            chk("rr_hdr", hs_q[k], (hdr_n % 2 == 0) ? 8'hE0 : 8'hE1);
            if (hdr_n > 0) chk("rr_gap", hs_t[k] - prev_t, L + 2);
            prev_t = hs_t[k];
            hdr_n++;
         end
      end
      chk("rr_count", hdr_n, 4);

      // Backpressure with ready pattern 1,0,0,1
      clear_logs();
      for (int k = 0; k < L; k++) push(0, 8'(8'h31 + k));
      for (int k = 0; k < 24; k++) begin
         bp_ready = (k % 4 == 0) || (k % 4 == 3);
         tick();
      end
      bp_ready = 1'b1;
      exp_se = '{8'hE0, 8'h31, 8'h32, 8'h33, 8'h34};
      chk("bp_len", hs_q.size(), 5);
      for (int k = 0; k < 5 && k < hs_q.size(); k++) chk("bp_byte", hs_q[k], exp_se[k]);
      chk("bp_pops0", pop_cnt[0], 4);

      // Flush to the active engine is deferred to the end of its packet
      clear_logs();
      push_pkt(0);
      tick();
      tick();
      tick();
      flush_req = 2'b01;
      tick();
      push_pkt(1);
      repeat (8) tick();
      chk("df_len", hs_q.size(), 10);
      if (hs_q.size() >= 6) begin
         chk("df_hdr0", hs_q[0], 8'hE0);
         chk("df_flush_t", flush_t[0], hs_t[4] + 1);
         chk("df_hdr1", hs_q[5], 8'hE1);
      end

      // Immediate flush to an idle engine excludes it from the grant
      clear_logs();
      push_pkt(0);
      push_pkt(1);
      flush_req = 2'b10;
      t0 = cyc;
      tick();
      repeat (8) tick();
      chk("if_flush_t", flush_t[1], t0 + 1);
      chk("if_len", hs_q.size(), 5);
      if (hs_q.size() > 0) chk("if_hdr", hs_q[0], 8'hE0);
      clear_logs();
      push_pkt(1);
      repeat (7) tick();
      chk("if_e1_later", (hs_q.size() > 0) ? hs_q[0] : 8'h00, 8'hE1);

      // Randomized traffic against the model
      for (int k = 0; k < 1500; k++) begin
         bp_ready = ($urandom_range(0, 3) != 0);
         cg       = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 15) == 0) engine_en = N'($urandom);
         if ($urandom_range(0, 31) == 0) flush_req[$urandom_range(0, N - 1)] = 1'b1;
         if ($urandom_range(0, 2) != 0) begin
            pe = $urandom_range(0, N - 1);
            if (fsize(pe) < 3 * L) push(pe, 8'($urandom));
         end
         tick();
      end
      cg        = 1'b1;
      engine_en = '1;
      bp_ready  = 1'b1;

      // Asynchronous reset in the middle of a packet body
      push_pkt(0);
      push_pkt(1);
      for (int k = 0; k < 40 && m_phase != 2; k++) tick();
      chk("ar_reach_body", m_phase, 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", bp_valid, 1'b0);
      chk("ar_pop", pop, '0);
      chk("ar_busy", busy, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_logs();
      push_pkt(0);
      push_pkt(1);
      repeat (3) tick();
      chk("ar_first_grant", (hs_q.size() > 0) ? hs_q[0] : 8'h00, 8'hE0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
